// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - multiply/divide scheduler owning the HI/LO register pair
//
// Sequences MULT/MULTU/DIV/DIVU issued from E stage over a fixed busy latency,
// performs MTHI/MTLO immediately, and stalls D-stage MDU instructions while busy.
//
// Ports:
//   clk      in   1   clock, rising edge
//   RESET    in   1   asynchronous active-low reset
//   Req      in   1   exception request; flushes this cycle's E-stage issue
//   E_start  in   1   E-stage MDU instruction valid
//   E_op     in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6/7 ignored)
//   E_A      in   32  rs operand
//   E_B      in   32  rt operand
//   D_ISMD   in   1   D-stage instruction is an MDU-class instruction
//   Busy     out  1   operation in progress
//   Stall_D  out  1   freeze F/D, bubble into D/E
//   HI       out  32  architectural HI
//   LO       out  32  architectural LO
//
// Optional feature macro: MDU_DIV0_FAST_EN (divide-by-zero finishes in one busy cycle).

module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        Req,
    input  logic        E_start,
    input  logic [2:0]  E_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_ISMD,
    output logic        Busy,
    output logic        Stall_D,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_we;

    logic        acc;
    logic        op_mul;
    logic        op_div;
    logic        op_signed;
    logic        div_zero;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic [3:0]  load_cnt;

    assign acc       = E_start & ~Req & (state == IDLE) & (E_op <= 3'd5);
    assign op_mul    = (E_op == 3'd0) | (E_op == 3'd1);
    assign op_div    = (E_op == 3'd2) | (E_op == 3'd3);
    assign op_signed = (E_op == 3'd0) | (E_op == 3'd2);
    assign div_zero  = (E_B == 32'd0);

    // D-stage mfhi/mflo must also wait behind an E-stage MTHI/MTLO, hence E_start.
    assign Stall_D = D_ISMD & (Busy | E_start);

    always_comb begin
        prod   = 64'd0;
        a_neg  = 1'b0;
        b_neg  = 1'b0;
        mag_a  = E_A;
        mag_b  = E_B;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (op_mul) begin
            // Low 64 bits of the product of sign-extended operands equal the signed product.
            if (op_signed)
                prod = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
            else
                prod = {32'd0, E_A} * {32'd0, E_B};
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else begin
            // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
            a_neg = op_signed & E_A[31];
            b_neg = op_signed & E_B[31];
            mag_a = a_neg ? (~E_A + 32'd1) : E_A;
            mag_b = b_neg ? (~E_B + 32'd1) : E_B;
            if (!div_zero) begin
                q_mag = mag_a / mag_b;
                r_mag = mag_a % mag_b;
            end
            res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end

    always_comb begin
        load_cnt = MULT_LOAD;
        if (op_div) begin
`ifdef MDU_DIV0_FAST_EN
            load_cnt = div_zero ? 4'd0 : DIV_LOAD;
`else
            load_cnt = DIV_LOAD;
`endif
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            Busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (E_op == 3'd4) begin
                            HI <= E_A;
                        end else if (E_op == 3'd5) begin
                            LO <= E_A;
                        end else begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            // Divide-by-zero still occupies the unit but leaves HI/LO alone.
                            pend_we <= ~(op_div & div_zero);
                            cnt     <= load_cnt;
                            state   <= BUSY;
                            Busy    <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (pend_we) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - directed scoreboard bench for mdu_sched

module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        RESET;
    logic        Req;
    logic        E_start;
    logic [2:0]  E_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_ISMD;
    logic        Busy;
    logic        Stall_D;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] sb[$];
    logic [31:0] mhi;
    logic [31:0] mlo;

`ifdef MDU_DIV0_FAST_EN
    localparam int DIV0_N = 1;
`else
    localparam int DIV0_N = 10;
`endif

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .RESET(RESET), .Req(Req), .E_start(E_start), .E_op(E_op),
        .E_A(E_A), .E_B(E_B), .D_ISMD(D_ISMD), .Busy(Busy), .Stall_D(Stall_D),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (RESET) begin
            assert (!(Busy && E_start)) else begin
                n_fails++;
                $error("FAIL e_start_while_busy: observed Busy=%0b E_start=%0b expected no overlap", Busy, E_start);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a mul/div op, expect it to stay busy exp_n cycles and then match the scoreboard.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_n, input logic [31:0] eh,
                          input logic [31:0] el, input int req_at);
        int n;
        logic [63:0] e;
        sb.push_back({eh, el});
        E_op = op; E_A = a; E_B = b; E_start = 1'b1; D_ISMD = 1'b1;
        #1;
        check({tag, "_stall_issue"}, 64'(Stall_D), 64'd1);
        @(posedge clk); #1;
        E_start = 1'b0;
        #1;
        check({tag, "_busy_start"}, 64'(Busy), 64'd1);
        check({tag, "_stall_busy"}, 64'(Stall_D), 64'd1);
        D_ISMD = 1'b0;
        n = 0;
        while (Busy && n < 40) begin
            Req = (n == req_at);
            @(posedge clk); #1;
            n++;
        end
        Req = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
        e = sb.pop_front();
        check({tag, "_hi"}, 64'(HI), 64'(e[63:32]));
        check({tag, "_lo"}, 64'(LO), 64'(e[31:0]));
        mhi = e[63:32];
        mlo = e[31:0];
    endtask

    task automatic run_mt(input string tag, input logic is_hi, input logic [31:0] a);
        E_op = is_hi ? 3'd4 : 3'd5; E_A = a; E_B = 32'd0; E_start = 1'b1; D_ISMD = 1'b1;
        #1;
        check({tag, "_stall_issue"}, 64'(Stall_D), 64'd1);
        @(posedge clk); #1;
        E_start = 1'b0;
        #1;
        if (is_hi) mhi = a; else mlo = a;
        check({tag, "_stall_after"}, 64'(Stall_D), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_hi"}, 64'(HI), 64'(mhi));
        check({tag, "_lo"}, 64'(LO), 64'(mlo));
        D_ISMD = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; Req = 1'b0; E_start = 1'b0; E_op = 3'd0;
        E_A = 32'd0; E_B = 32'd0; D_ISMD = 1'b0;
        mhi = 32'd0; mlo = 32'd0;
        #2;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hi", 64'(HI), 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        check("reset_stall", 64'(Stall_D), 64'd0);
        #10 RESET = 1'b1;
        @(posedge clk); #1;

        run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, -1);
        run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, -1);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, -1);
        run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, -1);

        run_mt("mtlo", 1'b0, 32'h1234);
        run_mt("mthi", 1'b1, 32'hAA);
        run_mt("mtlo2", 1'b0, 32'hBB);

        run_op("div_zero", 3'd2, 32'd55, 32'd0, DIV0_N, 32'hAA, 32'hBB, -1);

        // Flushed issue: stall still seen, nothing else happens.
        E_op = 3'd0; E_A = 32'd9; E_B = 32'd9; E_start = 1'b1; Req = 1'b1; D_ISMD = 1'b1;
        #1;
        check("req_flush_stall", 64'(Stall_D), 64'd1);
        @(posedge clk); #1;
        E_start = 1'b0; Req = 1'b0; D_ISMD = 1'b0;
        #1;
        check("req_flush_busy", 64'(Busy), 64'd0);
        check("req_flush_hilo", {HI, LO}, {32'hAA, 32'hBB});

        run_op("div_req_mid", 3'd2, 32'd100, 32'hFFFFFFF9, 10, 32'd2, 32'hFFFFFFF2, 3);

        // Asynchronous reset between edges in the middle of a MULT.
        E_op = 3'd0; E_A = 32'd3; E_B = 32'd5; E_start = 1'b1;
        @(posedge clk); #1;
        E_start = 1'b0;
        @(posedge clk); #3;
        check("mid_mult_busy", 64'(Busy), 64'd1);
        RESET = 1'b0;
        #1;
        check("async_rst_busy", 64'(Busy), 64'd0);
        check("async_rst_hilo", {HI, LO}, 64'd0);
        #2 RESET = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 64'(Busy), 64'd0);
        run_op("multu_after_rst", 3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'd1, 32'hFFFFFFFE, -1);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
